// File: rtl/analog_scan_if.sv
// analog_scan_if: command, pin-select and sample handshake bundle between reader side and scan controller
interface analog_scan_if #(parameter int NUM_PINS = 6);
  logic                start;
  logic                stop;
  logic                continuous;
  logic [NUM_PINS-1:0] pin_mask;
  logic                sample_ack;
  logic [NUM_PINS-1:0] pins_out;
  logic [2:0]          cur_pin;
  logic                sample_req;
  logic                busy;
  logic                done;
  logic                timeout_err;
  modport master (
    output start, stop, continuous, pin_mask, sample_ack,
    input  pins_out, cur_pin, sample_req, busy, done, timeout_err
  );
  modport slave (
    input  start, stop, continuous, pin_mask, sample_ack,
    output pins_out, cur_pin, sample_req, busy, done, timeout_err
  );
endinterface

// File: rtl/analog_scan_ctrl.sv
// analog_scan_ctrl: gated A0..A5 scan sequencer with settle time, sample handshake, abort and ack timeout
module analog_scan_ctrl #(
  parameter int NUM_PINS      = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic           arduino_clk,
  input  logic           reset,
  analog_scan_if.slave   bus
);
  localparam int PW = $clog2(NUM_PINS) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEARCH, SETTLE, REQ} state_t;
  state_t              state;
  logic [NUM_PINS-1:0] mask_q;
  logic                cont_q;
  logic [PW-1:0]       ptr;
  logic [SW-1:0]       settle_cnt;
  logic [TW-1:0]       to_cnt;
  logic                found;
  logic [2:0]          nxt;
  always_comb begin
    found = 1'b0;
    nxt = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--)
      if (mask_q[i] && PW'(i) >= ptr) begin
        found = 1'b1;
        nxt = 3'(i);
      end
  end
  always_ff @(posedge arduino_clk) begin
    if (reset) begin
      state           <= IDLE;
      mask_q          <= '0;
      cont_q          <= 1'b0;
      ptr             <= '0;
      settle_cnt      <= '0;
      to_cnt          <= '0;
      bus.pins_out    <= '0;
      bus.cur_pin     <= '0;
      bus.sample_req  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.stop) begin
        state          <= IDLE;
        bus.pins_out   <= '0;
        bus.sample_req <= 1'b0;
        bus.busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            mask_q          <= bus.pin_mask;
            cont_q          <= bus.continuous;
            ptr             <= '0;
            bus.timeout_err <= 1'b0;
            if (|bus.pin_mask) begin
              state    <= SEARCH;
              bus.busy <= 1'b1;
            end else bus.done <= 1'b1;
          end
          SEARCH: if (found) begin
            bus.pins_out <= NUM_PINS'(1) << nxt;
            bus.cur_pin  <= nxt;
            settle_cnt   <= '0;
            state        <= SETTLE;
          end else if (cont_q) ptr <= '0;
          else begin
            bus.pins_out <= '0;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
          SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            bus.sample_req <= 1'b1;
            to_cnt         <= '0;
            state          <= REQ;
          end else settle_cnt <= settle_cnt + 1'b1;
          REQ: if (bus.sample_ack || to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            bus.sample_req <= 1'b0;
            bus.pins_out   <= '0;
            ptr            <= PW'(bus.cur_pin) + PW'(1);
            state          <= SEARCH;
            if (!bus.sample_ack) bus.timeout_err <= 1'b1;
          end else to_cnt <= to_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_analog_scan_ctrl.sv
// tb_analog_scan_ctrl: scoreboard bench for analog_scan_ctrl (pin order, settle, latency, timeout, stop, reset)
module tb_analog_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int TMO    = 255;
  logic arduino_clk = 1'b0;
  logic reset = 1'b1;
  logic ack_auto_q = 1'b0;
  logic man_ack = 1'b0;
  bit   auto_ack = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  int   hold = 0;
  int   req_len = 0;
  int   last_req_len = 0;
  int   done_cnt = 0;
  int   base = 0;
  int   n;
  logic [5:0] prev_pins = '0;
  logic prev_req = 1'b0;
  analog_scan_if #(.NUM_PINS(6)) bus ();
  analog_scan_ctrl #(.NUM_PINS(6), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(TMO)) dut (
    .arduino_clk(arduino_clk),
    .reset(reset),
    .bus(bus.slave)
  );
  assign bus.sample_ack = ack_auto_q | man_ack;
  always #5 arduino_clk = ~arduino_clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int c);
    repeat (c) @(posedge arduino_clk);
    #1;
  endtask
  task automatic mon();
    int e;
    chk("onehot", {31'b0, $onehot0(bus.pins_out) && !(bus.sample_req && bus.pins_out == '0)}, 1);
    if (bus.done) begin
      done_cnt++;
      chk("busy_at_done", bus.busy, 0);
    end
    if (reset) begin
      hold = 0;
      req_len = 0;
    end else begin
      if (bus.pins_out != prev_pins) hold = 0;
      if (bus.pins_out != '0 && !bus.sample_req) hold++;
      if (bus.sample_req && !prev_req) begin
        if (exp_q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("cur_pin", bus.cur_pin, e);
          chk("pins_out", bus.pins_out, 1 << e);
          chk("settle", hold, SETTLE);
        end
      end
      if (bus.sample_req) req_len++;
      else if (prev_req) begin
        last_req_len = req_len;
        req_len = 0;
      end
    end
    ack_auto_q = auto_ack && bus.sample_req;
    prev_pins = bus.pins_out;
    prev_req = bus.sample_req;
  endtask
  task automatic wait_sig(input bit use_done, input int max, input string tag, output int cnt);
    logic f;
    cnt = 0;
    do begin
      @(negedge arduino_clk);
      cnt++;
      f = use_done ? bus.done : bus.sample_req;
    end while (!f && cnt < max);
    chk(tag, f, 1);
  endtask
  task automatic start_scan(input logic [5:0] m, input bit c, input int passes);
    bus.pin_mask = m;
    bus.continuous = c;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 6; i++)
        if (m[i]) exp_q.push_back(i);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_pins"}, bus.pins_out, 0);
    chk({tag, "_req"}, bus.sample_req, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.continuous = 1'b0;
    bus.pin_mask = '0;
    tick(3);
    @(negedge arduino_clk);
    chk_idle("rst");
    chk("rst_cur", bus.cur_pin, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.timeout_err, 0);
    fork
      forever begin
        @(negedge arduino_clk);
        mon();
      end
    join_none
    reset = 1'b0;
    tick(1);
    auto_ack = 0;
    start_scan(6'b001000, 0, 1);
    wait_sig(0, 20, "req1", n);
    reset = 1'b1;
    @(negedge arduino_clk);
    chk_idle("t1");
    chk("t1_cur", bus.cur_pin, 0);
    chk("t1_done", bus.done, 0);
    chk("t1_err", bus.timeout_err, 0);
    reset = 1'b0;
    exp_q.delete();
    tick(2);
    auto_ack = 1;
    base = done_cnt;
    start_scan(6'b111111, 0, 1);
    wait_sig(0, 20, "req2", n);
    chk("latency", n, 2 + SETTLE);
    wait_sig(1, 300, "done2", n);
    tick(2);
    chk("done_once", done_cnt - base, 1);
    chk("sb_drained2", exp_q.size(), 0);
    chk("t2_busy", bus.busy, 0);
    base = done_cnt;
    start_scan(6'b100101, 1, 3);
    for (int k = 0; k < 7; k++) wait_sig(0, 30, "req3", n);
    chk("t3_no_done", done_cnt - base, 0);
    chk("t3_left", exp_q.size(), 2);
    tick(1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk_idle("t3_stop");
    tick(3);
    chk("t3_no_done_stop", done_cnt - base, 0);
    exp_q.delete();
    start_scan(6'b000000, 0, 1);
    chk("t4_done", bus.done, 1);
    chk_idle("t4");
    tick(1);
    chk("t4_done_pulse", bus.done, 0);
    chk("t4_busy2", bus.busy, 0);
    auto_ack = 0;
    base = done_cnt;
    start_scan(6'b000010, 0, 1);
    wait_sig(0, 20, "req5", n);
    wait_sig(1, 400, "done5", n);
    tick(2);
    chk("t5_req_len", last_req_len, TMO);
    chk("t5_err", bus.timeout_err, 1);
    chk("t5_done", done_cnt - base, 1);
    auto_ack = 1;
    start_scan(6'b000001, 0, 1);
    chk("t5_err_clr", bus.timeout_err, 0);
    wait_sig(1, 50, "done5b", n);
    tick(2);
    auto_ack = 0;
    base = done_cnt;
    start_scan(6'b000011, 0, 1);
    wait_sig(0, 20, "req6a", n);
    tick(1);
    bus.start = 1'b1;
    bus.pin_mask = 6'b000100;
    bus.continuous = 1'b1;
    tick(1);
    bus.start = 1'b0;
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    tick(1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    wait_sig(0, 20, "req6b", n);
    bus.stop = 1'b1;
    man_ack = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    man_ack = 1'b0;
    chk_idle("t6_stop");
    tick(3);
    chk("t6_no_done", done_cnt - base, 0);
    chk("t6_sb", exp_q.size(), 0);
    chk("t6_idle_busy", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
